dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data-cache controller between the CPU load/store stage and the byte-addressed data memory.
- The data memory has a 128-bit combinational block read and a 64-bit synchronous write.
- The controller holds tag/valid/data arrays and sequences refills and write-throughs with an FSM.
- It exposes a valid/ready request interface and a one-cycle response pulse to the core.

Parameters:
- NUM_LINES, 16: number of 16-byte lines; must be a power of 2 and at least 2. INDEX_W = log2(NUM_LINES).
- MEM_LATENCY, 2: cycles mem_read is held before the block is sampled; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- cpu_req_valid  input  1  request present
- cpu_req_write  input  1  1 = store, 0 = load
- cpu_req_addr  input  64  byte address; bits [2:0] ignored, treated as 0
- cpu_req_wdata  input  64  store data
- cpu_req_ready  output  1  request accepted when valid && ready
- cpu_resp_valid  output  1  one-cycle completion pulse, for loads and stores
- cpu_resp_rdata  output  64  load data, valid with cpu_resp_valid; 0 for stores
- mem_address  output  64  to data memory
- mem_write_data  output  64  to data memory
- mem_write  output  1  to data memory
- mem_read  output  1  to data memory
- mem_block_data  input  128  block read from data memory; byte 0 in [7:0]
- hit_count  output  32  saturating load-hit counter
- miss_count  output  32  saturating load-miss counter

Behaviour:
- Address split:
  - offset = addr[3:0]; word select = addr[3]
  - index = addr[4+INDEX_W-1:4]
  - tag = addr[63:4+INDEX_W]
- Reset: all valid bits 0, state IDLE, counters 0. Outputs are 0 except cpu_req_ready = 1.
- Reset mid-operation: aborts any refill or write-through on the next edge; no line is filled.
- FSM states:
  - IDLE: cpu_req_ready = 1. On accept, latch addr, wdata and write flag.
    - Load hit: go to RESP. cpu_resp_rdata = line word[addr[3]]. hit_count increments.
    - Load miss: go to REFILL. miss_count increments.
    - Store: go to WRITE.
  - REFILL: mem_read = 1, mem_address = {addr[63:4], 4'b0}, held MEM_LATENCY cycles (counter).
    - On the last cycle, sample mem_block_data into the line, set tag, set valid.
    - Go to RESP with the selected word.
  - WRITE: mem_write = 1 for exactly one cycle. mem_address = {addr[63:3], 3'b0}, mem_write_data = wdata.
    - On a hit, the cached word is updated in the same cycle.
    - On a miss, no allocation.
    - Then go to WAIT.
  - WAIT: idle for MEM_LATENCY-1 cycles (0 cycles if MEM_LATENCY = 1), then go to RESP.
  - RESP: cpu_resp_valid = 1 for one cycle; cpu_req_ready = 0; return to IDLE.
- Latencies, from the accept edge to cpu_resp_valid:
  - load hit: 1 cycle
  - load miss: MEM_LATENCY + 1 cycles
  - store: MEM_LATENCY + 1 cycles
- cpu_req_ready is 0 in every state except IDLE. No new request is accepted until the response pulse has ended.
- mem_read and mem_write are never high together. Both are 0 outside REFILL/WRITE, and mem_address is 0 there too.
- Store to a line during its own refill is impossible (single outstanding request).
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Hit/miss detection and the data array lookup are combinational on cpu_req_addr in IDLE. Array writes are registered.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, REFILL, WRITE, WAIT, RESP}
  - LINE_BYTES = 16, OFFSET_W = 4
  - function for tag/index extraction
- Sub-module dcache_array: tag, valid and 128-bit data storage, with:
  - combinational read
  - synchronous line fill
  - synchronous word write
  - synchronous clear-all on reset
- FSM, counters and memory-port muxing stay in dcache_controller.

Test Plan:
- Cold load, addr 0x40, memory bytes 0x40..0x4F = 0x00..0x0F (MEM_LATENCY = 2) -> mem_read high 2 cycles at 0x40; resp at accept+3 with rdata 0x0706050403020100; miss_count = 1.
- Load 0x48 immediately after -> hit; resp at accept+1, rdata 0x0F0E0D0C0B0A0908; no mem_read; hit_count = 1.
- Store 0x48 = 0xDEADBEEFCAFEF00D, then load 0x48 -> one-cycle mem_write at 0x48; load hits and returns 0xDEADBEEFCAFEF00D.
- Store to uncached 0x200, then load 0x200 -> write-through occurs; the load misses (no-write-allocate) and refill returns the stored value.
- Conflict: load 0x40, load 0x40 + 16*NUM_LINES (0x140), load 0x40 -> three misses, miss_count = 3.
- Reset asserted on the second REFILL cycle -> next cycle mem_read = 0, cpu_req_ready = 1, counters 0; a subsequent load 0x40 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [2:0] {IDLE, REFILL, WRITE, WAIT, RESP} state_t;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_w);
    return (addr >> OFFSET_W) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_w);
    return addr >> (OFFSET_W + index_w);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational lookup, registered line fill and word write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int INDEX_W   = 4,
  parameter int TAG_W     = 56
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic [LINE_BYTES*8-1:0] rd_data,
  input  logic                  fill_en,
  input  logic [INDEX_W-1:0]    fill_index,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_BYTES*8-1:0] fill_data,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic                  wr_word,
  input  logic [63:0]           wr_data
);

  logic [NUM_LINES-1:0]    valid;
  logic [TAG_W-1:0]        tags [NUM_LINES];
  logic [LINE_BYTES*8-1:0] data [NUM_LINES];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

  always_ff @(posedge clk) begin
    if (reset) valid <= '0;
    else if (fill_en) valid[fill_index] <= 1'b1;
  end

  // Tag/data need no reset: a line is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index] <= fill_tag;
      data[fill_index] <= fill_data;
    end else if (wr_en) begin
      if (wr_word) data[wr_index][127:64] <= wr_data;
      else         data[wr_index][63:0]   <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_write,
  input  logic [63:0]  cpu_req_addr,
  input  logic [63:0]  cpu_req_wdata,
  output logic         cpu_req_ready,
  output logic         cpu_resp_valid,
  output logic [63:0]  cpu_resp_rdata,
  output logic [63:0]  mem_address,
  output logic [63:0]  mem_write_data,
  output logic         mem_write,
  output logic         mem_read,
  input  logic [127:0] mem_block_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 64 - OFFSET_W - INDEX_W;
  localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [63:OFFSET_W]   req_line;
  logic                 req_word;
  logic                 req_hit;

  logic [INDEX_W-1:0]   lk_index;
  logic [TAG_W-1:0]     lk_tag, rd_tag;
  logic                 rd_valid, hit, last;
  logic [127:0]         rd_data;
  logic [63:0]          rd_word;
  logic                 fill_en, wr_en;
  logic                 unused_addr;

  assign unused_addr = ^cpu_req_addr[2:0];
  assign lk_index    = INDEX_W'(addr_index(cpu_req_addr, INDEX_W));
  assign lk_tag      = TAG_W'(addr_tag(cpu_req_addr, INDEX_W));
  assign hit         = rd_valid && (rd_tag == lk_tag);
  assign rd_word     = cpu_req_addr[3] ? rd_data[127:64] : rd_data[63:0];
  assign last        = (cnt == CNT_W'(MEM_LATENCY - 1));
  assign fill_en     = !reset && (state == REFILL) && last;
  assign wr_en       = !reset && (state == WRITE) && req_hit;

  dcache_array #(.NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (lk_index),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fill_en    (fill_en),
    .fill_index (req_line[OFFSET_W +: INDEX_W]),
    .fill_tag   (req_line[63:OFFSET_W+INDEX_W]),
    .fill_data  (mem_block_data),
    .wr_en      (wr_en),
    .wr_index   (req_line[OFFSET_W +: INDEX_W]),
    .wr_word    (req_word),
    .wr_data    (mem_write_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      req_line       <= '0;
      req_word       <= 1'b0;
      req_hit        <= 1'b0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req_valid) begin
          req_line      <= cpu_req_addr[63:OFFSET_W];
          req_word      <= cpu_req_addr[3];
          req_hit       <= hit;
          cpu_req_ready <= 1'b0;
          if (cpu_req_write) begin
            state          <= WRITE;
            mem_write      <= 1'b1;
            mem_address    <= {cpu_req_addr[63:3], 3'b0};
            mem_write_data <= cpu_req_wdata;
          end else if (hit) begin
            state          <= RESP;
            cpu_resp_valid <= 1'b1;
            cpu_resp_rdata <= rd_word;
            hit_count      <= (hit_count == '1) ? hit_count : hit_count + 32'd1;
          end else begin
            state       <= REFILL;
            cnt         <= '0;
            mem_read    <= 1'b1;
            mem_address <= {cpu_req_addr[63:4], 4'b0};
            miss_count  <= (miss_count == '1) ? miss_count : miss_count + 32'd1;
          end
        end
        REFILL: if (last) begin
          state          <= RESP;
          mem_read       <= 1'b0;
          mem_address    <= '0;
          cpu_resp_valid <= 1'b1;
          cpu_resp_rdata <= req_word ? mem_block_data[127:64] : mem_block_data[63:0];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        WRITE: begin
          mem_write      <= 1'b0;
          mem_address    <= '0;
          mem_write_data <= '0;
          // WAIT counts from 1 so the same "last" compare ends both memory phases.
          if (MEM_LATENCY == 1) begin
            state          <= RESP;
            cpu_resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: if (last) begin
          state          <= RESP;
          cpu_resp_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RESP: begin
          state          <= IDLE;
          cpu_resp_valid <= 1'b0;
          cpu_resp_rdata <= '0;
          cpu_req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench: driver predicts each response from a cache/memory model, monitor checks it.
module tb_dcache_controller;

  localparam int NUM_LINES   = 16;
  localparam int MEM_LATENCY = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_write = 1'b0;
  logic [63:0]  cpu_req_addr = '0;
  logic [63:0]  cpu_req_wdata = '0;
  logic         cpu_req_ready, cpu_resp_valid;
  logic [63:0]  cpu_resp_rdata, mem_address, mem_write_data;
  logic         mem_write, mem_read;
  logic [127:0] mem_block_data;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_controller #(.NUM_LINES(NUM_LINES), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_block_data(mem_block_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [63:0] rdata, maddr, wdata;
    int          lat, rd, wr, acc;
    logic [31:0] hits, misses;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, vectors = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Backing store: 4 KiB window, unwritten bytes follow a fixed pattern.
  function automatic logic [7:0] init_byte(input int a);
    if (a >= 'h40 && a < 'h50) return 8'(a - 'h40);
    return 8'((a * 37) ^ (a >> 5) ^ 'h5A);
  endfunction

  logic [7:0] env_mem [4096];
  bit         env_wr  [4096];

  always @(posedge clk)
    if (mem_write)
      for (int k = 0; k < 8; k++) begin
        env_mem[int'(mem_address[11:3]) * 8 + k] <= mem_write_data[k*8 +: 8];
        env_wr [int'(mem_address[11:3]) * 8 + k] <= 1'b1;
      end

  always_comb begin
    mem_block_data = '0;
    for (int k = 0; k < 16; k++) begin
      int a;
      a = int'(mem_address[11:4]) * 16 + k;
      mem_block_data[k*8 +: 8] = env_wr[a] ? env_mem[a] : init_byte(a);
    end
  end

  // Reference model: line-level hit/miss bookkeeping plus a flat byte memory.
  logic [7:0]  ref_mem [4096];
  bit          ref_wr  [4096];
  bit          m_valid [NUM_LINES];
  logic [63:0] m_tag   [NUM_LINES];
  logic [31:0] m_hits = 0, m_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input bit wr, input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    int n, base, idx;
    logic [63:0] line, tg;
    bit hit;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 64) begin @(negedge clk); n++; end
    if (!cpu_req_ready) begin
      vectors++; errors++;
      $display("FAIL ready_timeout: got 0, expected 1 (cycle %0d)", cyc);
      return;
    end
    base = int'(a[11:3]) * 8;
    line = a >> 4;
    idx  = int'(line % NUM_LINES);
    tg   = line / NUM_LINES;
    e.acc = cyc; e.wdata = '0; e.rdata = '0;
    if (wr) begin
      for (int k = 0; k < 8; k++) begin ref_mem[base+k] = d[k*8 +: 8]; ref_wr[base+k] = 1'b1; end
      e.lat = MEM_LATENCY + 1; e.rd = 0; e.wr = 1;
      e.maddr = {a[63:3], 3'b0}; e.wdata = d;
    end else begin
      hit = m_valid[idx] && m_tag[idx] == tg;
      for (int k = 0; k < 8; k++)
        e.rdata[k*8 +: 8] = ref_wr[base+k] ? ref_mem[base+k] : init_byte(base+k);
      if (hit) begin
        if (m_hits != '1) m_hits++;
        e.lat = 1; e.rd = 0; e.maddr = '0;
      end else begin
        if (m_miss != '1) m_miss++;
        m_valid[idx] = 1'b1; m_tag[idx] = tg;
        e.lat = MEM_LATENCY + 1; e.rd = MEM_LATENCY; e.maddr = {a[63:4], 4'b0};
      end
      e.wr = 0;
    end
    e.hits = m_hits; e.misses = m_miss;
    sb.push_back(e);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = a; cpu_req_wdata = d;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  // Monitor
  initial begin
    int rd_cnt, wr_cnt;
    exp_t e;
    rd_cnt = 0; wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        chk("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
        if (mem_read) begin
          rd_cnt++;
          if (sb.size() > 0) chk("refill_addr", mem_address, sb[0].maddr);
        end else if (mem_write) begin
          wr_cnt++;
          if (sb.size() > 0) begin
            chk("wt_addr", mem_address, sb[0].maddr);
            chk("wt_data", mem_write_data, sb[0].wdata);
          end
        end else begin
          chk("mem_addr_idle", mem_address, 64'd0);
        end
        if (cpu_resp_valid) begin
          if (sb.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_resp: got resp, expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("rdata", cpu_resp_rdata, e.rdata);
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("read_cycles", 64'(rd_cnt), 64'(e.rd));
            chk("write_cycles", 64'(wr_cnt), 64'(e.wr));
            chk("hit_count", 64'(hit_count), 64'(e.hits));
            chk("miss_count", 64'(miss_count), 64'(e.misses));
            chk("ready_in_resp", 64'(cpu_req_ready), 64'd0);
          end
          rd_cnt = 0; wr_cnt = 0;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(cpu_req_ready), 64'd1);
    chk({tag, "_resp"}, 64'(cpu_resp_valid), 64'd0);
    chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
    chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
    chk({tag, "_mem_addr"}, mem_address, 64'd0);
    chk({tag, "_hits"}, 64'(hit_count), 64'd0);
    chk({tag, "_misses"}, 64'(miss_count), 64'd0);
  endtask

  // Driver
  initial begin
    logic [63:0] a, d;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    issue(0, 64'h40, 64'h0);
    issue(0, 64'h48, 64'h0);
    issue(1, 64'h48, 64'hDEADBEEFCAFEF00D);
    issue(0, 64'h48, 64'h0);
    issue(0, 64'h4D, 64'h0);
    issue(1, 64'h200, 64'h1122334455667788);
    issue(0, 64'h200, 64'h0);
    issue(0, 64'h140, 64'h0);
    issue(0, 64'h40, 64'h0);
    issue(0, 64'h1_0000_0000_0040, 64'h0);
    issue(0, 64'h40, 64'h0);

    // Abort a refill on its second memory cycle.
    issue(0, 64'h300, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    sb.delete();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_miss = 0;
    reset = 1'b0;
    issue(0, 64'h40, 64'h0);
    issue(0, 64'h300, 64'h0);

    for (int i = 0; i < 300; i++) begin
      a = 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) a[40] = 1'b1;
      d = {$urandom, $urandom};
      issue($urandom_range(0, 2) == 0, a, d);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      vectors++; errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
